// File: rtl/pio_out_pulse_cap.sv
// ---------------------------------------------------------------------------
// pio_out_pulse_cap
//  Avalon-MM PIO slave. It has a WIDTH-bit output register with atomic
//  set/clear. Bits selected by pulse_mask auto-clear after pulse_len cycles,
//  so the register can be used for one-shot SW->HW handshakes. A WIDTH-bit
//  input port is synchronised, its rising edges are captured in edge_cap, and
//  a maskable level IRQ is raised from the captured edges.
//
//  Ports
//   clk, reset   system clock, asynchronous active-high reset
//   address      word address: 0 data, 1 pulse_mask, 2 irq_mask,
//                3 edge_cap (W1C), 4 outset, 5 outclear, 6 pulse_len,
//                7 in_sync
//   chipselect   slave select; write = chipselect & ~write_n
//   write_n      active-low write strobe
//   writedata    write data; bits above WIDTH are ignored
//   readdata     combinational read mux, zero-extended
//   in_port      asynchronous status inputs
//   out_port     current output register value
//   irq          |(edge_cap & irq_mask)
// ---------------------------------------------------------------------------
module pio_out_pulse_cap #(
    parameter int unsigned             WIDTH       = 1,
    parameter logic [WIDTH-1:0]        RESET_VALUE = '0,
    parameter int unsigned             PCNT_W      = 16,
    parameter int unsigned             PULSE_RST   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [WIDTH-1:0]  in_port,
    output logic [WIDTH-1:0]  out_port,
    output logic              irq
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} cnt_state_t;

    logic [WIDTH-1:0]  data_out_r;
    logic [WIDTH-1:0]  pulse_mask_r;
    logic [WIDTH-1:0]  irq_mask_r;
    logic [WIDTH-1:0]  edge_cap_r;
    logic [PCNT_W-1:0] pulse_len_r;
    logic [PCNT_W-1:0] cnt_r;
    cnt_state_t        state_r;
    logic [WIDTH-1:0]  sync1_r;
    logic [WIDTH-1:0]  in_sync_r;
    logic [WIDTH-1:0]  prev_r;

    logic              write_s;
    logic [WIDTH-1:0]  wd_s;
    logic              expire_s;
    logic [WIDTH-1:0]  base_s;
    logic [WIDTH-1:0]  wr_val_s;
    logic [WIDTH-1:0]  hold_val_s;
    logic              trig_s;
    logic [WIDTH-1:0]  data_next_s;
    logic [WIDTH-1:0]  rise_s;
    logic [PCNT_W-1:0] load_s;
    logic [31:0]       rd_s;
    logic              unused_s;

    assign write_s  = chipselect & ~write_n;
    assign wd_s     = writedata[WIDTH-1:0];
    assign unused_s = ^writedata;
    assign expire_s = (state_r == RUN) && (cnt_r == PCNT_W'(1));
    assign rise_s   = in_sync_r & ~prev_r;
    assign load_s   = (pulse_len_r == '0) ? PCNT_W'(1) : pulse_len_r;

    // Next output-register value: expiry clear, then SW write on top of it.
    always_comb begin
        base_s     = expire_s ? (data_out_r & ~pulse_mask_r) : data_out_r;
        wr_val_s   = base_s;
        hold_val_s = data_out_r;
        trig_s     = 1'b0;
        if (write_s) begin
            case (address)
                3'd0: begin
                    wr_val_s   = wd_s;
                    hold_val_s = wd_s;
                end
                3'd4: begin
                    wr_val_s   = base_s | wd_s;
                    hold_val_s = data_out_r | wd_s;
                end
                3'd5: begin
                    wr_val_s   = base_s & ~wd_s;
                    hold_val_s = data_out_r & ~wd_s;
                end
                default: begin
                    wr_val_s   = base_s;
                    hold_val_s = data_out_r;
                end
            endcase
            // A 0->1 pulse bit is judged against the post-expiry value, so
            // re-setting a bit on its own expiry cycle restarts the pulse.
            trig_s = ((address == 3'd0) || (address == 3'd4)) &&
                     (|(wr_val_s & ~base_s & pulse_mask_r));
        end else begin
            trig_s = 1'b0;
        end
        // On a reload the expiry clear is skipped entirely.
        data_next_s = trig_s ? hold_val_s : wr_val_s;
    end

    // Output, mask, length and edge-capture registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out_r   <= RESET_VALUE;
            pulse_mask_r <= '0;
            irq_mask_r   <= '0;
            edge_cap_r   <= '0;
            pulse_len_r  <= PCNT_W'(PULSE_RST);
        end else begin
            data_out_r <= data_next_s;
            if (write_s && (address == 3'd1)) begin
                pulse_mask_r <= wd_s;
            end
            if (write_s && (address == 3'd2)) begin
                irq_mask_r <= wd_s;
            end
            if (write_s && (address == 3'd6)) begin
                pulse_len_r <= writedata[PCNT_W-1:0];
            end
            // New rise beats a coincident W1C on the same bit.
            if (write_s && (address == 3'd3)) begin
                edge_cap_r <= (edge_cap_r & ~wd_s) | rise_s;
            end else begin
                edge_cap_r <= edge_cap_r | rise_s;
            end
        end
    end

    // Pulse counter FSM: load on a new pulse bit, count down to expiry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= '0;
        end else if (trig_s) begin
            state_r <= RUN;
            cnt_r   <= load_s;
        end else begin
            case (state_r)
                RUN: begin
                    if (cnt_r == PCNT_W'(1)) begin
                        state_r <= IDLE;
                        cnt_r   <= '0;
                    end else begin
                        cnt_r <= cnt_r - PCNT_W'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    // Two-flop synchroniser plus previous-value register for edge detect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r   <= '0;
            in_sync_r <= '0;
            prev_r    <= '0;
        end else begin
            sync1_r   <= in_port;
            in_sync_r <= sync1_r;
            prev_r    <= in_sync_r;
        end
    end

    // Read mux, zero-extended to the bus width.
    always_comb begin
        rd_s = 32'd0;
        case (address)
            3'd0:    rd_s[WIDTH-1:0]  = data_out_r;
            3'd1:    rd_s[WIDTH-1:0]  = pulse_mask_r;
            3'd2:    rd_s[WIDTH-1:0]  = irq_mask_r;
            3'd3:    rd_s[WIDTH-1:0]  = edge_cap_r;
            3'd6:    rd_s[PCNT_W-1:0] = pulse_len_r;
            3'd7:    rd_s[WIDTH-1:0]  = in_sync_r;
            default: rd_s = 32'd0;
        endcase
    end

    assign readdata = rd_s;
    assign out_port = data_out_r;
    assign irq      = |(edge_cap_r & irq_mask_r);

endmodule

// File: tb/tb_pio_out_pulse_cap.sv
module tb_pio_out_pulse_cap;

    localparam int unsigned W = 8;
    localparam logic [7:0]  RV = 8'h5A;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  in_port;
    logic [7:0]  out_port;
    logic        irq;

    int n_cmp  = 0;
    int n_fail = 0;

    pio_out_pulse_cap #(
        .WIDTH(W), .RESET_VALUE(RV), .PCNT_W(16), .PULSE_RST(1)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .in_port(in_port), .out_port(out_port), .irq(irq)
    );

    always #5 clk = ~clk;

    // Called at a negedge: one-cycle write, returns at the next negedge.
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        rd(3'd0, d);
        n_cmp++; if (d !== 32'h5A) begin n_fail++; $display("FAIL por_data got %h exp %h", d, 32'h5A); end
        rd(3'd1, d);
        n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL por_pmask got %h exp 0", d); end
        rd(3'd6, d);
        n_cmp++; if (d !== 32'h1) begin n_fail++; $display("FAIL por_plen got %h exp 1", d); end
        n_cmp++; if (out_port !== RV || irq !== 1'b0) begin n_fail++; $display("FAIL por_out got %h/%b exp 5a/0", out_port, irq); end
    endtask

    task automatic test_set_clear;
        logic [31:0] d;
        wr(3'd0, 32'h0F);
        wr(3'd4, 32'hF0);
        wr(3'd5, 32'h81);
        n_cmp++; if (out_port !== 8'h7E) begin n_fail++; $display("FAIL setclr_out got %h exp 7e", out_port); end
        rd(3'd0, d);
        n_cmp++; if (d !== 32'h7E) begin n_fail++; $display("FAIL setclr_rd got %h exp 7e", d); end
    endtask

    task automatic test_pulse;
        int hi;
        wr(3'd1, 32'h01);
        wr(3'd6, 32'd5);
        wr(3'd4, 32'h01);
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_port[0]) hi++;
            @(negedge clk);
        end
        n_cmp++; if (hi !== 5) begin n_fail++; $display("FAIL pulse5_len got %0d exp 5", hi); end
        n_cmp++; if (out_port !== 8'h7E) begin n_fail++; $display("FAIL pulse5_after got %h exp 7e", out_port); end
        wr(3'd6, 32'd0);
        wr(3'd4, 32'h01);
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_port[0]) hi++;
            @(negedge clk);
        end
        n_cmp++; if (hi !== 1) begin n_fail++; $display("FAIL pulse0_len got %0d exp 1", hi); end
    endtask

    task automatic test_back_to_back;
        int hi;
        wr(3'd6, 32'd5);
        wr(3'd4, 32'h01);           // E0
        repeat (4) @(negedge clk);  // now before E5 (expiry edge)
        wr(3'd4, 32'h01);           // re-set on expiry
        n_cmp++; if (out_port[0] !== 1'b1) begin n_fail++; $display("FAIL reload_bit got %b exp 1", out_port[0]); end
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_port[0]) hi++;
            @(negedge clk);
        end
        n_cmp++; if (hi !== 5) begin n_fail++; $display("FAIL reload_len got %0d exp 5", hi); end
        wr(3'd4, 32'h01);
        repeat (4) @(negedge clk);
        wr(3'd5, 32'h02);           // clear bit1 on expiry edge
        n_cmp++; if (out_port !== 8'h7C) begin n_fail++; $display("FAIL clr_on_exp got %h exp 7c", out_port); end
        repeat (8) @(negedge clk);
        n_cmp++; if (out_port !== 8'h7C) begin n_fail++; $display("FAIL clr_on_exp_hold got %h exp 7c", out_port); end
    endtask

    task automatic test_edge_capture;
        logic [31:0] d;
        wr(3'd2, 32'h04);
        in_port = 8'h04;            // before E0
        @(negedge clk);
        @(negedge clk);             // after E1
        rd(3'd3, d);
        n_cmp++; if (d !== 32'h0 || irq !== 1'b0) begin n_fail++; $display("FAIL edge_early got %h/%b exp 0/0", d, irq); end
        @(negedge clk);             // after E2
        rd(3'd3, d);
        n_cmp++; if (d !== 32'h04) begin n_fail++; $display("FAIL edge_cap got %h exp 04", d); end
        n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL edge_irq got %b exp 1", irq); end
        @(negedge clk);
        wr(3'd3, 32'h04);
        n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL w1c_irq got %b exp 0", irq); end
        in_port = 8'h00;
        repeat (5) @(negedge clk);
        in_port = 8'h04;
        @(negedge clk);
        @(negedge clk);             // rise visible before E2
        wr(3'd3, 32'h04);           // W1C on E2
        rd(3'd3, d);
        n_cmp++; if (d !== 32'h04 || irq !== 1'b1) begin n_fail++; $display("FAIL w1c_vs_rise got %h/%b exp 04/1", d, irq); end
        @(negedge clk);
    endtask

    task automatic test_unmapped;
        logic [31:0] d;
        rd(3'd4, d);
        n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL rd_addr4 got %h exp 0", d); end
        rd(3'd5, d);
        n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL rd_addr5 got %h exp 0", d); end
        rd(3'd7, d);
        n_cmp++; if (d !== 32'h04) begin n_fail++; $display("FAIL rd_insync got %h exp 04", d); end
        @(negedge clk);
        wr(3'd1, 32'h0);
        wr(3'd0, 32'h1234_5633);
        rd(3'd0, d);
        n_cmp++; if (d !== 32'h33 || out_port !== 8'h33) begin n_fail++; $display("FAIL wide_data got %h/%h exp 33", d, out_port); end
        @(negedge clk);
        wr(3'd0, 32'hFFFF_FF00);
        n_cmp++; if (out_port !== 8'h00) begin n_fail++; $display("FAIL wide_hi got %h exp 00", out_port); end
        wr(3'd6, 32'hABCD_0007);
        rd(3'd6, d);
        n_cmp++; if (d !== 32'h7) begin n_fail++; $display("FAIL wide_plen got %h exp 7", d); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        wr(3'd1, 32'h01);
        wr(3'd6, 32'd100);
        wr(3'd4, 32'h01);
        repeat (3) @(negedge clk);
        n_cmp++; if (out_port !== 8'h01 || irq !== 1'b1) begin n_fail++; $display("FAIL pre_rst got %h/%b exp 01/1", out_port, irq); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (out_port !== RV || irq !== 1'b0) begin n_fail++; $display("FAIL mid_rst_out got %h/%b exp 5a/0", out_port, irq); end
        rd(3'd1, d);
        n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL mid_rst_pmask got %h exp 0", d); end
        rd(3'd2, d);
        n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL mid_rst_imask got %h exp 0", d); end
        rd(3'd3, d);
        n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL mid_rst_ecap got %h exp 0", d); end
        rd(3'd6, d);
        n_cmp++; if (d !== 32'h1) begin n_fail++; $display("FAIL mid_rst_plen got %h exp 1", d); end
        @(negedge clk);
        reset = 1'b0;
        wr(3'd1, 32'h01);
        repeat (4) @(negedge clk);
        n_cmp++; if (out_port !== RV) begin n_fail++; $display("FAIL post_rst_idle got %h exp 5a", out_port); end
    endtask

    initial begin
        reset      = 1'b1;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        in_port    = 8'h00;
        repeat (3) @(negedge clk);
        test_reset;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        test_set_clear;
        test_pulse;
        test_back_to_back;
        test_edge_capture;
        test_unmapped;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
